frobenius_norm_ctrl: RTL and testbench

FROBENIUS_NORM_CTRL -- requirements
Module: frobenius_norm_ctrl

---
 rtl/frobenius_norm_ctrl_if.sv | 44 ++++
 rtl/frobenius_norm_ctrl.sv | 139 +++++++++++++
 tb/tb_frobenius_norm_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frobenius_norm_ctrl_if.sv
// -----------------------------------------------------------------------------
// frobenius_norm_ctrl_if
// Bundles the element-memory read port and the shared square-root handshake
// used by frobenius_norm_ctrl.
//   mem_rd_en    : element read strobe (controller -> memory)
//   mem_row      : read row index
//   mem_col      : read column index
//   mem_rd_data  : signed element, valid one cycle after mem_rd_en
//   sqrt_req     : square-root request (controller -> sqrt unit)
//   sqrt_operand : sum of squares, held stable while sqrt_req is high
//   sqrt_ack     : sqrt_result valid this cycle
//   sqrt_result  : floor square root of sqrt_operand
// Modports: master = controller side, slave = memory / sqrt-unit side.
// -----------------------------------------------------------------------------
interface frobenius_norm_ctrl_if #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int DATA_W = 32
);
    localparam int N     = SIZE_A * SIZE_B;
    localparam int ACC_W = 2 * DATA_W + $clog2(N) + 1;
    localparam int RES_W = (ACC_W + 1) / 2;
    localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int COL_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

    logic                     mem_rd_en;
    logic [ROW_W-1:0]         mem_row;
    logic [COL_W-1:0]         mem_col;
    logic signed [DATA_W-1:0] mem_rd_data;
    logic                     sqrt_req;
    logic [ACC_W-1:0]         sqrt_operand;
    logic                     sqrt_ack;
    logic [RES_W-1:0]         sqrt_result;

    modport master (
        output mem_rd_en, mem_row, mem_col, sqrt_req, sqrt_operand,
        input  mem_rd_data, sqrt_ack, sqrt_result
    );

    modport slave (
        input  mem_rd_en, mem_row, mem_col, sqrt_req, sqrt_operand,
        output mem_rd_data, sqrt_ack, sqrt_result
    );
endinterface

// File: rtl/frobenius_norm_ctrl.sv
// -----------------------------------------------------------------------------
// frobenius_norm_ctrl
// Reads a SIZE_A x SIZE_B signed matrix row-major, accumulates the sum of
// squares, hands it to a shared square-root unit and reports the result as
// the Frobenius norm.
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin one computation (sampled only in IDLE)
//   abort      : cancel the computation in READ/DRAIN/SQRT
//   busy       : high in every state except IDLE
//   norm       : last completed norm, held until next completion or reset
//   norm_valid : one-cycle completion pulse
//   bus        : memory read port and sqrt handshake (master modport)
// -----------------------------------------------------------------------------
module frobenius_norm_ctrl #(
    parameter  int SIZE_A = 8,
    parameter  int SIZE_B = 8,
    parameter  int DATA_W = 32,
    localparam int N      = SIZE_A * SIZE_B,
    localparam int ACC_W  = 2 * DATA_W + $clog2(N) + 1,
    localparam int RES_W  = (ACC_W + 1) / 2,
    localparam int ROW_W  = (SIZE_A > 1) ? $clog2(SIZE_A) : 1,
    localparam int COL_W  = (SIZE_B > 1) ? $clog2(SIZE_B) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic [RES_W-1:0]      norm,
    output logic                  norm_valid,
    frobenius_norm_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, SQRT, DONE} state_t;

    state_t             state_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [ACC_W-1:0]   acc_q;
    logic               data_vld_q;
    logic               mem_rd_en_q;
    logic               sqrt_req_q;
    logic [RES_W-1:0]   norm_q;
    logic               norm_valid_q;

    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           sq_ext;
    logic                       last_addr;

    // The signed square is never negative and at most 2^(2*DATA_W-2), so the
    // 2*DATA_W-bit product can be taken as unsigned without loss.
    assign prod      = bus.mem_rd_data * bus.mem_rd_data;
    assign sq_ext    = {{(ACC_W-2*DATA_W){1'b0}}, prod};
    assign last_addr = (row_q == ROW_W'(SIZE_A-1)) && (col_q == COL_W'(SIZE_B-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            acc_q        <= '0;
            data_vld_q   <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            sqrt_req_q   <= 1'b0;
            norm_q       <= '0;
            norm_valid_q <= 1'b0;
        end else begin
            norm_valid_q <= 1'b0;
            // Read data arrives one cycle after the strobe.
            data_vld_q   <= mem_rd_en_q;
            if (data_vld_q) begin
                acc_q <= acc_q + sq_ext;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Overrides any straggling accumulate from an aborted run.
                        acc_q       <= '0;
                        row_q       <= '0;
                        col_q       <= '0;
                        mem_rd_en_q <= 1'b1;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        mem_rd_en_q <= 1'b0;
                        data_vld_q  <= 1'b0;
                        state_q     <= IDLE;
                    end else if (last_addr) begin
                        mem_rd_en_q <= 1'b0;
                        state_q     <= DRAIN;
                    end else if (col_q == COL_W'(SIZE_B-1)) begin
                        col_q <= '0;
                        row_q <= row_q + ROW_W'(1);
                    end else begin
                        col_q <= col_q + COL_W'(1);
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        data_vld_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        sqrt_req_q <= 1'b1;
                        state_q    <= SQRT;
                    end
                end
                SQRT: begin
                    if (abort) begin
                        sqrt_req_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (bus.sqrt_ack) begin
                        norm_q       <= bus.sqrt_result;
                        norm_valid_q <= 1'b1;
                        sqrt_req_q   <= 1'b0;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy             = (state_q != IDLE);
    assign norm             = norm_q;
    assign norm_valid       = norm_valid_q;
    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.mem_row      = row_q;
    assign bus.mem_col      = col_q;
    assign bus.sqrt_req     = sqrt_req_q;
    assign bus.sqrt_operand = acc_q;
endmodule

// File: tb/tb_frobenius_norm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frobenius_norm_ctrl
// Bench for frobenius_norm_ctrl: a 2x2 and an 8x8 instance (DATA_W=32) with
// behavioural element memories and square-root stubs with programmable delay.
// -----------------------------------------------------------------------------
module tb_frobenius_norm_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- 2x2 instance ----------------
    logic        start2 = 1'b0, abort2 = 1'b0;
    logic        busy2, nv2;
    logic [33:0] norm2;
    frobenius_norm_ctrl_if #(.SIZE_A(2), .SIZE_B(2), .DATA_W(32)) bus2();
    frobenius_norm_ctrl #(.SIZE_A(2), .SIZE_B(2), .DATA_W(32)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .busy(busy2), .norm(norm2), .norm_valid(nv2), .bus(bus2)
    );

    // ---------------- 8x8 instance ----------------
    logic        start8 = 1'b0, abort8 = 1'b0;
    logic        busy8, nv8;
    logic [35:0] norm8;
    frobenius_norm_ctrl_if #(.SIZE_A(8), .SIZE_B(8), .DATA_W(32)) bus8();
    frobenius_norm_ctrl #(.SIZE_A(8), .SIZE_B(8), .DATA_W(32)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8),
        .busy(busy8), .norm(norm8), .norm_valid(nv8), .bus(bus8)
    );

    function automatic logic [35:0] isqrt(input logic [71:0] v);
        logic [35:0] r;
        logic [79:0] t;
        r = '0;
        for (int b = 35; b >= 0; b--) begin
            t = 80'(r | (36'(1) << b));
            if (t * t <= 80'(v)) r = r | (36'(1) << b);
        end
        return r;
    endfunction

    // Element memories
    logic [31:0] val2 [4];
    int          mode8 = 0;
    always @(posedge clk) begin
        if (bus2.mem_rd_en) bus2.mem_rd_data <= val2[{bus2.mem_row, bus2.mem_col}];
        if (bus8.mem_rd_en) begin
            if (mode8 == 0) bus8.mem_rd_data <= 32'(int'(bus8.mem_row) - int'(bus8.mem_col));
            else            bus8.mem_rd_data <= 32'(int'(bus8.mem_row) + int'(bus8.mem_col));
        end
    end

    // Square-root stubs: ack once sqrt_req has been high for dly cycles
    int   dly2 = 0, dly8 = 0, wc2 = 0, wc8 = 0;
    logic force_ack2 = 1'b0;
    always @(posedge clk) begin
        wc2 <= bus2.sqrt_req ? wc2 + 1 : 0;
        wc8 <= bus8.sqrt_req ? wc8 + 1 : 0;
    end
    assign bus2.sqrt_ack    = force_ack2 | (bus2.sqrt_req && (wc2 >= dly2));
    assign bus2.sqrt_result = 34'(isqrt(72'(bus2.sqrt_operand)));
    assign bus8.sqrt_ack    = bus8.sqrt_req && (wc8 >= dly8);
    assign bus8.sqrt_result = isqrt(72'(bus8.sqrt_operand));

    // Scoreboards: expected norms pushed at start, popped on norm_valid
    logic [33:0] exp2_q[$];
    logic [35:0] exp8_q[$];
    int          nv2_cnt = 0, nv8_cnt = 0;
    always @(negedge clk) begin
        if (nv2 === 1'b1) begin
            nv2_cnt++;
            tests++;
            if (exp2_q.size() == 0) begin
                fails++;
                $display("FAIL sb2_unexpected: norm_valid with norm=%0d, none expected", norm2);
            end else begin
                logic [33:0] e2;
                e2 = exp2_q.pop_front();
                if (norm2 !== e2) begin
                    fails++;
                    $display("FAIL sb2_norm: got %0d expected %0d", norm2, e2);
                end
            end
        end
        if (nv8 === 1'b1) begin
            nv8_cnt++;
            tests++;
            if (exp8_q.size() == 0) begin
                fails++;
                $display("FAIL sb8_unexpected: norm_valid with norm=%0d, none expected", norm8);
            end else begin
                logic [35:0] e8;
                e8 = exp8_q.pop_front();
                if (norm8 !== e8) begin
                    fails++;
                    $display("FAIL sb8_norm: got %0d expected %0d", norm8, e8);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy2, bus2.mem_rd_en, bus2.sqrt_req, nv2} !== 4'b0 || norm2 !== 34'd0) begin
            fails++;
            $display("FAIL reset2: busy=%b rd=%b req=%b nv=%b norm=%0d, expected all 0",
                     busy2, bus2.mem_rd_en, bus2.sqrt_req, nv2, norm2);
        end
        tests++;
        if ({busy8, bus8.mem_rd_en, bus8.sqrt_req, nv8} !== 4'b0 || norm8 !== 36'd0) begin
            fails++;
            $display("FAIL reset8: busy=%b rd=%b req=%b nv=%b norm=%0d, expected all 0",
                     busy8, bus8.mem_rd_en, bus8.sqrt_req, nv8, norm8);
        end
        rst = 1'b0;
    endtask

    task automatic test_small_pattern();
        int k, reads;
        for (int i = 0; i < 4; i++) val2[i] = 32'd3;
        dly2 = 0;
        exp2_q.push_back(34'd6);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        k = 1;
        reads = 0;
        while (nv2 !== 1'b1 && k < 50) begin
            if (bus2.mem_rd_en) reads++;
            if (bus2.sqrt_req) begin
                tests++;
                if (bus2.sqrt_operand !== 67'd36) begin
                    fails++;
                    $display("FAIL small_operand: got %0d expected 36", bus2.sqrt_operand);
                end
            end
            @(negedge clk);
            k++;
        end
        tests++;
        if (k !== 7) begin
            fails++;
            $display("FAIL small_latency: norm_valid at cycle %0d expected 7", k);
        end
        tests++;
        if (reads !== 4) begin
            fails++;
            $display("FAIL small_reads: got %0d expected 4", reads);
        end
        @(negedge clk);
    endtask

    task automatic test_min_value();
        int k;
        logic [66:0] exp_op;
        exp_op = 67'd1 << 64;
        for (int i = 0; i < 4; i++) val2[i] = 32'h8000_0000;
        exp2_q.push_back(34'd1 << 32);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        k = 1;
        while (nv2 !== 1'b1 && k < 50) begin
            if (bus2.sqrt_req) begin
                tests++;
                if (bus2.sqrt_operand !== exp_op) begin
                    fails++;
                    $display("FAIL min_operand: got %0h expected %0h", bus2.sqrt_operand, exp_op);
                end
            end
            @(negedge clk);
            k++;
        end
        tests++;
        if (nv2 !== 1'b1) begin
            fails++;
            $display("FAIL min_timeout: no norm_valid within %0d cycles", k);
        end
        @(negedge clk);
    endtask

    task automatic test_r_minus_c();
        int k, idx, req_cnt;
        mode8 = 0;
        dly8 = 5;
        exp8_q.push_back(36'd25);
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        k = 1;
        idx = 0;
        req_cnt = 0;
        while (nv8 !== 1'b1 && k < 200) begin
            if (bus8.mem_rd_en) begin
                tests++;
                if (int'(bus8.mem_row) != idx / 8 || int'(bus8.mem_col) != idx % 8) begin
                    fails++;
                    $display("FAIL rc_addr: read %0d at (%0d,%0d) expected (%0d,%0d)",
                             idx, bus8.mem_row, bus8.mem_col, idx / 8, idx % 8);
                end
                idx++;
            end
            if (bus8.sqrt_req) begin
                req_cnt++;
                tests++;
                if (bus8.sqrt_operand !== 71'd672) begin
                    fails++;
                    $display("FAIL rc_operand: got %0d expected 672", bus8.sqrt_operand);
                end
            end
            @(negedge clk);
            k++;
        end
        tests++;
        if (idx !== 64) begin
            fails++;
            $display("FAIL rc_reads: got %0d expected 64", idx);
        end
        tests++;
        if (req_cnt !== 6) begin
            fails++;
            $display("FAIL rc_req_cycles: got %0d expected 6", req_cnt);
        end
        dly8 = 0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int k, base;
        mode8 = 0;
        base = nv8_cnt;
        exp8_q.push_back(36'd25);
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        k = 1;
        while (nv8 !== 1'b1 && k < 200) begin
            start8 = (k == 10);
            @(negedge clk);
            k++;
        end
        // Pulse start during the DONE cycle.
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (80) @(negedge clk);
        tests++;
        if (nv8_cnt - base !== 1) begin
            fails++;
            $display("FAIL ignore_count: %0d norm_valid pulses expected 1", nv8_cnt - base);
        end
        tests++;
        if (busy8 !== 1'b0) begin
            fails++;
            $display("FAIL ignore_busy: busy=%b expected 0", busy8);
        end
    endtask

    task automatic test_abort();
        int k, base;
        mode8 = 1;
        base = nv8_cnt;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        tests++;
        if (busy8 !== 1'b0 || bus8.mem_rd_en !== 1'b0 || norm8 !== 36'd25) begin
            fails++;
            $display("FAIL abort_idle: busy=%b rd=%b norm=%0d expected 0/0/25",
                     busy8, bus8.mem_rd_en, norm8);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (nv8_cnt !== base) begin
            fails++;
            $display("FAIL abort_pulse: %0d pulses after abort expected 0", nv8_cnt - base);
        end
        // start with abort in IDLE must still start
        exp8_q.push_back(36'd61);
        start8 = 1'b1;
        abort8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        abort8 = 1'b0;
        tests++;
        if (busy8 !== 1'b1) begin
            fails++;
            $display("FAIL abort_start: busy=%b expected 1", busy8);
        end
        k = 0;
        while (nv8 !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (norm8 !== 36'd61) begin
            fails++;
            $display("FAIL abort_rerun: norm=%0d expected 61", norm8);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_sqrt();
        int k, base;
        for (int i = 0; i < 4; i++) val2[i] = 32'd3;
        dly2 = 1000;
        base = nv2_cnt;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (bus2.sqrt_req !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (bus2.sqrt_req !== 1'b1) begin
            fails++;
            $display("FAIL rst_sqrt_reach: sqrt_req=%b expected 1", bus2.sqrt_req);
        end
        force_ack2 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_ack2 = 1'b0;
        tests++;
        if ({busy2, bus2.mem_rd_en, bus2.sqrt_req, nv2} !== 4'b0 || norm2 !== 34'd0
            || bus2.sqrt_operand !== 67'd0) begin
            fails++;
            $display("FAIL rst_sqrt: busy=%b rd=%b req=%b nv=%b norm=%0d op=%0d expected all 0",
                     busy2, bus2.mem_rd_en, bus2.sqrt_req, nv2, norm2, bus2.sqrt_operand);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (nv2_cnt !== base) begin
            fails++;
            $display("FAIL rst_sqrt_pulse: %0d pulses after reset expected 0", nv2_cnt - base);
        end
        dly2 = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) val2[i] = '0;
        @(negedge clk);
        test_reset();
        test_small_pattern();
        test_min_value();
        test_r_minus_c();
        test_start_ignored();
        test_abort();
        test_reset_in_sqrt();
        tests++;
        if (exp2_q.size() != 0 || exp8_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d/%0d expected results never produced",
                     exp2_q.size(), exp8_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
